// File: rtl/mod_execute.sv
// Execute stage: single-cycle ALU ops plus an iterative radix-2 shift-add
// unsigned 64x64 multiply, with a one-entry EX/WB output register.
package mod_execute_pkg;
   typedef struct packed {
      logic [63:0] pc_contents;
      logic [63:0] alu_result;
      logic [63:0] alu_ext_result;
      logic [7:0]  ctl_opcode;
      logic [3:0]  ctl_regByte;
      logic [3:0]  ctl_rmByte;
      logic        sim_end;
   } ex_wb_t;
endpackage

module mod_execute
   import mod_execute_pkg::*;
#(
   parameter int MUL_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        idex_valid,
   output logic        idex_ready,
   input  logic [63:0] idex_pc,
   input  logic [7:0]  idex_opcode,
   input  logic [3:0]  idex_regByte,
   input  logic [3:0]  idex_rmByte,
   input  logic [2:0]  idex_ext,
   input  logic [63:0] idex_op_a,
   input  logic [63:0] idex_op_b,
   input  logic        idex_sim_end,
   output ex_wb_t      exwb,
   output logic        exwb_valid,
   input  logic        can_writeback,
   output logic        busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam int         CW     = $clog2(MUL_CYCLES + 1);

   logic [1:0]   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [63:0]  mcand_q, mcand_d;
   logic [127:0] prod_q, prod_d;
   ex_wb_t       pend_q, pend_d;
   ex_wb_t       exwb_q, exwb_d;
   logic         vld_q, vld_d;

   logic         slot_free, accept, is_mul;
   ex_wb_t       ctl;

   // One shift-add step: the multiplier sits in the low half and is shifted
   // out as the partial product grows into the high half.
   function automatic logic [127:0] mul_step(input logic [127:0] p, input logic [63:0] m);
      logic [64:0] s;
      s = {1'b0, p[127:64]} + (p[0] ? {1'b0, m} : 65'd0);
      return {s, p[63:1]};
   endfunction

   assign slot_free  = !vld_q || can_writeback;
   assign idex_ready = (state_q == S_IDLE) && slot_free;
   assign accept     = idex_valid && idex_ready;
   assign is_mul     = (idex_opcode == 8'd247) && (idex_ext == 3'd4);
   assign busy       = (state_q != S_IDLE);
   assign exwb       = exwb_q;
   assign exwb_valid = vld_q;

   // Control capture and single-cycle ALU result for the offered instruction
   always_comb begin
      ctl                = '0;
      ctl.pc_contents    = idex_pc;
      ctl.ctl_opcode     = idex_opcode;
      ctl.ctl_regByte    = idex_regByte;
      ctl.ctl_rmByte     = idex_rmByte;
      ctl.sim_end        = idex_sim_end;
      unique casez (idex_opcode)
         8'h01:     ctl.alu_result = idex_op_a + idex_op_b;
         8'h29:     ctl.alu_result = idex_op_a - idex_op_b;
         8'h21:     ctl.alu_result = idex_op_a & idex_op_b;
         8'h09:     ctl.alu_result = idex_op_a | idex_op_b;
         8'h31:     ctl.alu_result = idex_op_a ^ idex_op_b;
         8'h5?:     ctl.alu_result = idex_op_a;
         8'hC3, 8'hE8, 8'hFF: ctl.alu_result = idex_pc;
         default:   ctl.alu_result = idex_op_b;
      endcase
   end

   // Next-state: accept, iterate the multiply, and load the EX/WB slot
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mcand_d = mcand_q;
      prod_d  = prod_q;
      pend_d  = pend_q;
      exwb_d  = exwb_q;
      vld_d   = vld_q && !can_writeback;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (is_mul) begin
                  // First iteration runs on the accept edge so the result is
                  // ready to load MUL_CYCLES edges later.
                  mcand_d = idex_op_a;
                  prod_d  = mul_step({64'd0, idex_op_b}, idex_op_a);
                  cnt_d   = CW'(1);
                  pend_d  = ctl;
                  state_d = (MUL_CYCLES == 1) ? S_DONE : S_MUL;
               end else begin
                  exwb_d = ctl;
                  vld_d  = 1'b1;
               end
            end
         end
         S_MUL: begin
            prod_d = mul_step(prod_q, mcand_q);
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(MUL_CYCLES - 1)) state_d = S_DONE;
         end
         S_DONE: begin
            if (slot_free) begin
               exwb_d                = pend_q;
               exwb_d.alu_result     = prod_q[63:0];
               exwb_d.alu_ext_result = prod_q[127:64];
               vld_d                 = 1'b1;
               cnt_d                 = '0;
               state_d               = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset aborts any multiply in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
         pend_q  <= '0;
         exwb_q  <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         pend_q  <= pend_d;
         exwb_q  <= exwb_d;
         vld_q   <= vld_d;
      end
   end

endmodule
